// File: rtl/bandpass_pkg.sv
// rtl/bandpass_pkg.sv - shared types and widths for the bandpass sample sequencer
package bandpass_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 10;
    localparam int CLIP_MAX = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/bandpass_fifo.sv
// rtl/bandpass_fifo.sv - DEPTH x W synchronous sample FIFO with full/empty and discard
module bandpass_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp[AW-1:0]];

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; discard has priority over push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bandpass_seq_ctrl.sv
// rtl/bandpass_seq_ctrl.sv - paces samples into the bandpass filter and collects results; BPF_CLIP_EN clips results to 8 bits
module bandpass_seq_ctrl
    import bandpass_pkg::*;
#(
    parameter int DIV       = 1,
    parameter int LAT       = 2,
    parameter int DEPTH     = 4,
    parameter int FLUSH_LEN = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic           clr_flags,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X_W-1:0] in_data,
    output logic [X_W-1:0] filt_x,
    input  logic [Y_W-1:0] filt_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Y_W-1:0] out_data,
    output logic           busy,
    output logic           underrun,
    output logic           overrun
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = $clog2(FLUSH_LEN + 1);

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [FW-1:0]  fcnt;
    logic [LAT-1:0] tag_pipe;
    logic [LAT-1:0] tag_nx;
    logic           rst_done;

    logic           tick;
    logic           run_tick;
    logic           flush_tick;
    logic           issue;
    logic           emerge;
    logic           flush_done;
    logic [Y_W-1:0] y_cap;

    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_clr;
    logic           fifo_full;
    logic           fifo_empty;
    logic [X_W-1:0] fifo_rdata;

    assign tick       = (state != ST_IDLE) && (cnt == CW'(DIV - 1));
    assign run_tick   = tick && (state == ST_RUN);
    assign flush_tick = tick && (state == ST_FLUSH);
    assign issue      = run_tick && !fifo_empty;
    assign emerge     = tag_pipe[LAT-1];
    assign flush_done = (fcnt == FW'(FLUSH_LEN));

    // rst_done keeps in_ready low until the first clock after reset release.
    assign in_ready   = rst_done && !fifo_full && (state != ST_FLUSH);
    assign fifo_push  = in_valid && in_ready;
    assign fifo_pop   = issue;
    assign fifo_clr   = (state == ST_RUN) && stop;
    assign busy       = (state != ST_IDLE);

`ifdef BPF_CLIP_EN
    assign y_cap = (filt_y > Y_W'(CLIP_MAX)) ? Y_W'(CLIP_MAX) : filt_y;
`else
    assign y_cap = filt_y;
`endif

    bandpass_fifo #(
        .DEPTH (DEPTH),
        .W     (X_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Marks the first clock after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: stop beats start in IDLE; FLUSH leaves once zeros are done and no tag is in flight.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nx = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_done && (tag_pipe == '0)) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Sample-rate divider; held at zero in IDLE so RUN always starts a fresh period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if ((state == ST_IDLE) || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Counts zero samples pushed into the filter during FLUSH, saturating at FLUSH_LEN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt <= '0;
        end else if (state != ST_FLUSH) begin
            fcnt <= '0;
        end else if (flush_tick && !flush_done) begin
            fcnt <= fcnt + 1'b1;
        end
    end

    // Next tag-pipe contents: shift by one, inject a tag only for real samples.
    always_comb begin
        tag_nx    = tag_pipe << 1;
        tag_nx[0] = issue;
    end

    // Tag pipe tracks which filter outputs correspond to real samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe <= tag_nx;
        end
    end

    // Filter input: new sample on a RUN tick with data, zero on any other tick, hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_x <= '0;
        end else if (tick) begin
            filt_x <= issue ? fifo_rdata : '0;
        end
    end

    // Result register: a newly emerging result always loads, overwriting an unconsumed one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (emerge) begin
            out_valid <= 1'b1;
            out_data  <= y_cap;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky underrun: a RUN tick found the FIFO empty; setting beats clearing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun <= 1'b0;
        end else if (run_tick && fifo_empty) begin
            underrun <= 1'b1;
        end else if (clr_flags) begin
            underrun <= 1'b0;
        end
    end

    // Sticky overrun: a result was replaced before the consumer took it; setting beats clearing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (emerge && out_valid && !out_ready) begin
            overrun <= 1'b1;
        end else if (clr_flags) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bandpass_seq_ctrl.sv
// tb/tb_bandpass_seq_ctrl.sv - self-checking bench for bandpass_seq_ctrl
module tb_bandpass_seq_ctrl;

    localparam int DIV       = 1;
    localparam int LAT       = 2;
    localparam int DEPTH     = 4;
    localparam int FLUSH_LEN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, stop = 1'b0, clr_flags = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, out_valid, busy, underrun, overrun;
    logic [7:0] filt_x;
    logic [9:0] filt_y = '0;
    logic [9:0] out_data;

    logic       start_4 = 1'b0, stop_4 = 1'b0, clr_4 = 1'b0, in_valid_4 = 1'b0;
    logic [7:0] in_data_4 = '0;
    logic       in_ready_4, out_valid_4, busy_4, underrun_4, overrun_4;
    logic [7:0] filt_x_4;
    logic [9:0] filt_y_4;
    logic [9:0] out_data_4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bandpass_seq_ctrl #(.DIV(DIV), .LAT(LAT), .DEPTH(DEPTH), .FLUSH_LEN(FLUSH_LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr_flags(clr_flags),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .filt_x(filt_x), .filt_y(filt_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .underrun(underrun), .overrun(overrun)
    );

    bandpass_seq_ctrl #(.DIV(4), .LAT(LAT), .DEPTH(DEPTH), .FLUSH_LEN(FLUSH_LEN)) dut4 (
        .clk(clk), .rst(rst), .start(start_4), .stop(stop_4), .clr_flags(clr_4),
        .in_valid(in_valid_4), .in_ready(in_ready_4), .in_data(in_data_4),
        .filt_x(filt_x_4), .filt_y(filt_y_4),
        .out_valid(out_valid_4), .out_ready(1'b1), .out_data(out_data_4),
        .busy(busy_4), .underrun(underrun_4), .overrun(overrun_4)
    );

    assign filt_y_4 = {2'b00, filt_x_4};

    function automatic logic [9:0] filt_fn(input logic [7:0] x);
        int v;
        v = (int'(x) * 5 + 3) % 1024;
        return 10'(v);
    endfunction

    function automatic logic [9:0] clipf(input logic [9:0] y);
`ifdef BPF_CLIP_EN
        return (y > 10'd255) ? 10'd255 : y;
`else
        return y;
`endif
    endfunction

    // External filter stand-in: the response to an x value is seen LAT clocks after x changed.
    logic [7:0] hist [LAT];
    initial for (int i = 0; i < LAT; i++) hist[i] = '0;
    always @(negedge clk) begin
        for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = filt_x;
        filt_y = filt_fn(hist[LAT-1]);
    end

    // Behavioural model of the main instance.
    typedef struct {
        int         due;
        logic [9:0] val;
    } pend_t;

    int         m_state;
    int         m_cnt, m_fcnt, m_edge;
    bit         m_rdone;
    logic [7:0] m_fifo [$];
    pend_t      m_pend [$];
    logic [7:0] m_fx;
    logic [9:0] m_od;
    bit         m_ov, m_ur, m_or;

    function automatic bit m_in_ready();
        return m_rdone && (m_fifo.size() < DEPTH) && (m_state != 2);
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_fcnt = 0; m_edge = 0; m_rdone = 0;
        m_fifo.delete(); m_pend.delete();
        m_fx = '0; m_od = '0; m_ov = 0; m_ur = 0; m_or = 0;
    endtask

    task automatic model_step();
        bit tick, emerge, push, set_ur, set_or;
        int nstate;
        logic [7:0] s;
        push   = in_valid && m_in_ready();
        tick   = (m_state != 0) && (m_cnt == DIV - 1);
        emerge = (m_pend.size() > 0) && (m_pend[0].due == m_edge);
        set_ur = 0;
        set_or = 0;
        nstate = m_state;
        if (m_state == 0 && start && !stop) nstate = 1;
        else if (m_state == 1 && stop) nstate = 2;
        else if (m_state == 2 && m_fcnt == FLUSH_LEN && m_pend.size() == 0) nstate = 0;
        if (tick && m_state == 1) begin
            if (m_fifo.size() > 0) begin
                s = m_fifo.pop_front();
                m_fx = s;
                m_pend.push_back('{due: m_edge + LAT, val: clipf(filt_fn(s))});
            end else begin
                m_fx = '0;
                set_ur = 1;
            end
        end else if (tick && m_state == 2) begin
            m_fx = '0;
        end
        if (push) m_fifo.push_back(in_data);
        if (m_state == 1 && stop) m_fifo.delete();
        if (emerge) begin
            if (m_ov && !out_ready) set_or = 1;
            m_od = m_pend[0].val;
            void'(m_pend.pop_front());
            m_ov = 1;
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
        m_ur = set_ur || (m_ur && !clr_flags);
        m_or = set_or || (m_or && !clr_flags);
        if (m_state == 0) m_cnt = 0;
        else m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
        if (m_state != 2) m_fcnt = 0;
        else if (tick && m_fcnt < FLUSH_LEN) m_fcnt++;
        m_state = nstate;
        m_rdone = 1;
        m_edge++;
    endtask

    task automatic tick_clk();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            tick_clk();
        end
    endtask

    task automatic push_sample(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick_clk();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        model_reset();
        checks++;
        if ({filt_x, out_data, out_valid, in_ready, busy, underrun, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {filt_x, out_data, out_valid, in_ready, busy, underrun, overrun});
        end
        rst = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_release got %b exp 0", in_ready); end
        tick_clk();
        checks++;
        if (in_ready !== 1'b1 || in_ready_4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_after got %b/%b exp 1/1", in_ready, in_ready_4);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        push_sample(8'd7); push_sample(8'd9); push_sample(8'd11);
        start = 1'b1; tick_clk(); start = 1'b0;
        tick_clk();
        checks++;
        if (filt_x !== 8'd7 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre got filt_x %0d busy %b exp 7 1", filt_x, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({filt_x, out_data, out_valid, in_ready, busy, underrun, overrun} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs got %h exp 0", {filt_x, out_data, out_valid, in_ready, busy, underrun, overrun});
        end
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        tick_clk();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrun_in_ready got %b exp 1", in_ready); end
        start = 1'b1; tick_clk(); start = 1'b0;
        tick_clk();
        checks++;
        if (underrun !== 1'b1 || filt_x !== 8'd0) begin
            errors++;
            $display("FAIL midrun_fifo_empty got underrun %b filt_x %0d exp 1 0", underrun, filt_x);
        end
        stop = 1'b1; tick_clk(); stop = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midrun_idle_timeout got busy %b exp 0", busy); end
        clr_flags = 1'b1; tick_clk(); clr_flags = 1'b0;
    endtask

    task automatic test_prefill_stream();
        logic [7:0] vals [4];
        bit ok;
        vals[0] = 8'd5; vals[1] = 8'd10; vals[2] = 8'd12; vals[3] = 8'd15;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_sample(vals[i]);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL prefill_full_in_ready got %b exp 0", in_ready); end
        start = 1'b1; tick_clk(); start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            stop = (k == 4);
            tick_clk();
            if (k <= 4) begin
                checks++;
                if (filt_x !== vals[k-1]) begin
                    errors++;
                    $display("FAIL prefill_filt_x k=%0d got %0d exp %0d", k, filt_x, vals[k-1]);
                end
            end
            if (k >= 3 && k <= 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== clipf(filt_fn(vals[k-3]))) begin
                    errors++;
                    $display("FAIL prefill_result k=%0d got v%b %0d exp v1 %0d", k, out_valid, out_data, clipf(filt_fn(vals[k-3])));
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL prefill_no_valid k=%0d got %b exp 0", k, out_valid); end
            end
        end
        stop = 1'b0;
        checks++;
        if (underrun !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL prefill_flags got %b%b exp 00", underrun, overrun);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL prefill_idle_timeout got busy %b exp 0", busy); end
    endtask

    task automatic test_div4_underrun();
        in_valid_4 = 1'b1; in_data_4 = 8'd16; tick_clk(); in_valid_4 = 1'b0;
        start_4 = 1'b1; tick_clk(); start_4 = 1'b0;
        repeat (3) tick_clk();
        checks++;
        if (filt_x_4 !== 8'd0) begin errors++; $display("FAIL div4_before_tick got %0d exp 0", filt_x_4); end
        tick_clk();
        checks++;
        if (filt_x_4 !== 8'd16 || underrun_4 !== 1'b0) begin
            errors++;
            $display("FAIL div4_first_tick got %0d ur %b exp 16 0", filt_x_4, underrun_4);
        end
        repeat (3) tick_clk();
        checks++;
        if (underrun_4 !== 1'b0) begin errors++; $display("FAIL div4_pre_second got ur %b exp 0", underrun_4); end
        tick_clk();
        checks++;
        if (filt_x_4 !== 8'd0 || underrun_4 !== 1'b1) begin
            errors++;
            $display("FAIL div4_second_tick got %0d ur %b exp 0 1", filt_x_4, underrun_4);
        end
        clr_4 = 1'b1; tick_clk(); clr_4 = 1'b0;
        checks++;
        if (underrun_4 !== 1'b0) begin errors++; $display("FAIL div4_clr got ur %b exp 0", underrun_4); end
        stop_4 = 1'b1; tick_clk(); stop_4 = 1'b0;
        repeat (30) tick_clk();
        checks++;
        if (busy_4 !== 1'b0) begin errors++; $display("FAIL div4_idle got busy %b exp 0", busy_4); end
    endtask

    task automatic test_overrun();
        bit ok;
        out_ready = 1'b0;
        push_sample(8'd5); push_sample(8'd10);
        start = 1'b1; tick_clk(); start = 1'b0;
        repeat (3) tick_clk();
        checks++;
        if (out_valid !== 1'b1 || out_data !== clipf(filt_fn(8'd5)) || overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_first got v%b %0d or%b exp v1 %0d or0", out_valid, out_data, overrun, clipf(filt_fn(8'd5)));
        end
        tick_clk();
        checks++;
        if (out_valid !== 1'b1 || out_data !== clipf(filt_fn(8'd10)) || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_second got v%b %0d or%b exp v1 %0d or1", out_valid, out_data, overrun, clipf(filt_fn(8'd10)));
        end
        stop = 1'b1; tick_clk(); stop = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL overrun_stop_keeps_valid got %b exp 1", out_valid); end
        out_ready = 1'b1; tick_clk();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL overrun_consume got %b exp 0", out_valid); end
        wait_idle(ok);
        clr_flags = 1'b1; tick_clk(); clr_flags = 1'b0;
        checks++;
        if (!ok || underrun !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear got idle %b ur %b or %b exp 1 0 0", ok, underrun, overrun);
        end
    endtask

    task automatic test_stop_flush();
        int results, fall_k;
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_sample(8'(20 + i));
        start = 1'b1; tick_clk(); start = 1'b0;
        results = 0;
        fall_k = -1;
        for (int k = 1; k <= 20 && fall_k < 0; k++) begin
            stop = (k == 3);
            tick_clk();
            if (out_valid) results++;
            if (k == 3) begin
                checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_enter got in_ready %b busy %b exp 0 1", in_ready, busy);
                end
            end
            if (k >= 4) begin
                checks++;
                if (filt_x !== 8'd0) begin errors++; $display("FAIL flush_zero k=%0d got %0d exp 0", k, filt_x); end
            end
            if (!busy) fall_k = k;
        end
        stop = 1'b0;
        checks++;
        if (results != 3) begin errors++; $display("FAIL flush_results got %0d exp 3", results); end
        checks++;
        if (fall_k != 8) begin errors++; $display("FAIL flush_busy_fall got %0d exp 8", fall_k); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL flush_underrun got %b exp 0", underrun); end
        start = 1'b1; tick_clk(); start = 1'b0;
        tick_clk();
        checks++;
        if (underrun !== 1'b1 || filt_x !== 8'd0) begin
            errors++;
            $display("FAIL flush_fifo_discarded got ur %b filt_x %0d exp 1 0", underrun, filt_x);
        end
        stop = 1'b1; tick_clk(); stop = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL flush2_idle_timeout got busy %b exp 0", busy); end
        clr_flags = 1'b1; tick_clk(); clr_flags = 1'b0;
    endtask

    task automatic test_start_stop_same();
        start = 1'b1; stop = 1'b1; tick_clk(); start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_same got busy %b exp 0", busy); end
        tick_clk();
        checks++;
        if (busy !== 1'b0 || filt_x !== 8'd0) begin
            errors++;
            $display("FAIL start_stop_same_hold got busy %b filt_x %0d exp 0 0", busy, filt_x);
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            clr_flags = ($urandom_range(0, 24) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick_clk();
            checks++;
            if (filt_x !== m_fx) begin errors++; $display("FAIL rnd_filt_x cyc %0d got %0d exp %0d", c, filt_x, m_fx); end
            checks++;
            if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %b exp %b", c, out_valid, m_ov); end
            checks++;
            if (out_data !== m_od) begin errors++; $display("FAIL rnd_out_data cyc %0d got %0d exp %0d", c, out_data, m_od); end
            checks++;
            if (in_ready !== m_in_ready()) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b exp %b", c, in_ready, m_in_ready()); end
            checks++;
            if (busy !== (m_state != 0)) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, busy, m_state != 0); end
            checks++;
            if (underrun !== m_ur) begin errors++; $display("FAIL rnd_underrun cyc %0d got %b exp %b", c, underrun, m_ur); end
            checks++;
            if (overrun !== m_or) begin errors++; $display("FAIL rnd_overrun cyc %0d got %b exp %b", c, overrun, m_or); end
        end
        start = 1'b0; clr_flags = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        stop = 1'b1; tick_clk(); stop = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rnd_idle_timeout got busy %b exp 0", busy); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reset_mid_run();
        test_prefill_stream();
        test_div4_underrun();
        test_overrun();
        test_stop_flush();
        test_start_stop_same();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
